// File: rtl/syrup_outchannel_arbiter.sv
// rtl/syrup_outchannel_arbiter.sv - round-robin burst arbiter sharing one SyrupOutChannel write port
// Each grant is followed by one bubble cycle in IDLE; beats are tagged with the requester index.
module syrup_outchannel_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int TAG_W     = 2,
  parameter int W_D       = 32,
  parameter int MAX_BURST = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NUM_REQ-1:0]     REQ_VALID,
  input  logic [NUM_REQ*W_D-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]     REQ_READY,
  input  logic                   STALL,
  output logic [TAG_W+W_D-1:0]   CH_D,
  output logic                   CH_WE,
  output logic [TAG_W-1:0]       GRANT_ID,
  output logic                   BUSY
);

  if (NUM_REQ > (1 << TAG_W)) begin : g_tag_too_narrow
    $error("syrup_outchannel_arbiter: NUM_REQ exceeds 2**TAG_W");
  end
  if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
    $error("syrup_outchannel_arbiter: NUM_REQ must be 2..16");
  end
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_burst
    $error("syrup_outchannel_arbiter: MAX_BURST must be 1..255");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_nxt;
  logic [TAG_W-1:0] ptr, ptr_nxt;
  logic [TAG_W-1:0] gid_nxt;
  logic [TAG_W-1:0] sel;
  logic [7:0]       cnt, cnt_nxt;
  logic             found;
  logic             accept;
  int               idx;

  // First valid requester at or above the pointer, wrapping mod NUM_REQ.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && REQ_VALID[idx]) begin
        found = 1'b1;
        sel   = TAG_W'(idx);
      end
    end
  end

  assign accept = (state == GRANT) && REQ_VALID[GRANT_ID] && !STALL;
  assign BUSY   = (state == GRANT);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gid_nxt   = GRANT_ID;
    cnt_nxt   = cnt;
    REQ_READY = '0;
    case (state)
      IDLE: begin
        if (found) begin
          gid_nxt   = sel;
          cnt_nxt   = 8'd0;
          state_nxt = GRANT;
        end
      end
      GRANT: begin
        REQ_READY[GRANT_ID] = ~STALL;
        if (accept) begin
          cnt_nxt = cnt + 8'd1;
        end
        if (!REQ_VALID[GRANT_ID] || (accept && (cnt + 8'd1 == 8'(MAX_BURST)))) begin
          state_nxt = IDLE;
          ptr_nxt   = (GRANT_ID == TAG_W'(NUM_REQ - 1)) ? '0 : GRANT_ID + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= 8'd0;
      GRANT_ID <= '0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      cnt      <= cnt_nxt;
      GRANT_ID <= gid_nxt;
    end
  end

  // Accepted beat appears on the channel one cycle later; CH_D holds between writes.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      CH_WE <= 1'b0;
      CH_D  <= '0;
    end else begin
      CH_WE <= accept;
      if (accept) begin
        CH_D <= {GRANT_ID, REQ_DATA[int'(GRANT_ID)*W_D +: W_D]};
      end
    end
  end

endmodule

// File: tb/tb_syrup_outchannel_arbiter.sv
// tb/tb_syrup_outchannel_arbiter.sv - self-checking bench for syrup_outchannel_arbiter
module tb_syrup_outchannel_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  valid;
  logic [127:0] data;
  logic [3:0]  ready;
  logic        stall;
  logic [33:0] ch_d;
  logic        ch_we;
  logic [1:0]  gid;
  logic        busy;

  logic [3:0]  valid_b;
  logic [127:0] data_b;
  logic [3:0]  ready_b;
  logic        stall_b;
  logic [33:0] ch_d_b;
  logic        ch_we_b;
  logic [1:0]  gid_b;
  logic        busy_b;

  always #5 clk = ~clk;

  syrup_outchannel_arbiter #(.NUM_REQ(4), .TAG_W(2), .W_D(32), .MAX_BURST(8)) dut (
    .CLK(clk), .RST(rst_n), .REQ_VALID(valid), .REQ_DATA(data), .REQ_READY(ready),
    .STALL(stall), .CH_D(ch_d), .CH_WE(ch_we), .GRANT_ID(gid), .BUSY(busy)
  );

  syrup_outchannel_arbiter #(.NUM_REQ(4), .TAG_W(2), .W_D(32), .MAX_BURST(1)) dut_b (
    .CLK(clk), .RST(rst_n), .REQ_VALID(valid_b), .REQ_DATA(data_b), .REQ_READY(ready_b),
    .STALL(stall_b), .CH_D(ch_d_b), .CH_WE(ch_we_b), .GRANT_ID(gid_b), .BUSY(busy_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  valid;
    logic        stall;
    logic [31:0] d;
    logic [3:0]  ready;
    logic        busy;
    logic        we;
    logic [33:0] chd;
    logic [1:0]  gid;
  } vec_t;

  vec_t        vecs[15];
  logic [33:0] exp_q[$];
  int          tag_log[$];
  int          seq[4];

  function automatic vec_t mkv(input logic [3:0] v, input logic s, input logic [31:0] d,
                               input logic [3:0] r, input logic b, input logic w,
                               input logic [33:0] c, input logic [1:0] g);
    vec_t x;
    x.valid = v; x.stall = s; x.d = d; x.ready = r;
    x.busy = b; x.we = w; x.chd = c; x.gid = g;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One scoreboarded cycle: drive at negedge, check the channel, record accepted beats.
  task automatic cycle(input logic [3:0] v, input logic st);
    logic [33:0] e;
    @(negedge clk);
    valid = v;
    stall = st;
    for (int i = 0; i < 4; i++) data[i*32 +: 32] = (32'(i) << 16) | 32'(seq[i]);
    #1;
    if (exp_q.size() > 0) begin
      chk("sb_we", {63'd0, ch_we}, 64'd1);
      if (ch_we) begin
        e = exp_q.pop_front();
        chk("sb_chd", {30'd0, ch_d}, {30'd0, e});
      end
    end else begin
      chk("sb_we_idle", {63'd0, ch_we}, 64'd0);
    end
    if (st) chk("stall_ready", {60'd0, ready}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      if (v[i] && ready[i]) begin
        exp_q.push_back({2'(i), data[i*32 +: 32]});
        tag_log.push_back(i);
        seq[i]++;
      end
    end
  endtask

  initial begin
    logic [7:0] bwe;
    int         btag[8];
    int         cyc;

    vecs[0]  = mkv(4'b0001, 0, 32'h10, 4'b0000, 0, 0, 34'h0,          2'd0);
    vecs[1]  = mkv(4'b0001, 0, 32'h10, 4'b0001, 1, 0, 34'h0,          2'd0);
    vecs[2]  = mkv(4'b0001, 0, 32'h11, 4'b0001, 1, 1, 34'h0_0000_0010, 2'd0);
    vecs[3]  = mkv(4'b0001, 0, 32'h12, 4'b0001, 1, 1, 34'h0_0000_0011, 2'd0);
    vecs[4]  = mkv(4'b0000, 0, 32'h00, 4'b0001, 1, 1, 34'h0_0000_0012, 2'd0);
    vecs[5]  = mkv(4'b0000, 0, 32'h00, 4'b0000, 0, 0, 34'h0_0000_0012, 2'd0);
    vecs[6]  = mkv(4'b0100, 0, 32'h20, 4'b0000, 0, 0, 34'h0_0000_0012, 2'd0);
    vecs[7]  = mkv(4'b0100, 0, 32'h20, 4'b0100, 1, 0, 34'h0_0000_0012, 2'd2);
    vecs[8]  = mkv(4'b0000, 0, 32'h21, 4'b0100, 1, 1, 34'h2_0000_0020, 2'd2);
    vecs[9]  = mkv(4'b0010, 0, 32'h30, 4'b0000, 0, 0, 34'h2_0000_0020, 2'd2);
    vecs[10] = mkv(4'b0010, 0, 32'h30, 4'b0010, 1, 0, 34'h2_0000_0020, 2'd1);
    vecs[11] = mkv(4'b0000, 0, 32'h31, 4'b0010, 1, 1, 34'h1_0000_0030, 2'd1);
    vecs[12] = mkv(4'b1010, 0, 32'h40, 4'b0000, 0, 0, 34'h1_0000_0030, 2'd1);
    vecs[13] = mkv(4'b0000, 0, 32'h41, 4'b1000, 1, 0, 34'h1_0000_0030, 2'd3);
    vecs[14] = mkv(4'b0000, 0, 32'h00, 4'b0000, 0, 0, 34'h1_0000_0030, 2'd3);
    bwe  = 8'b0101_0100;
    btag = '{0, 0, 0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 4; i++) seq[i] = 0;

    rst_n = 1'b0; valid = '0; data = '0; stall = 1'b0;
    valid_b = '0; stall_b = 1'b0;
    for (int i = 0; i < 4; i++) data_b[i*32 +: 32] = 32'hB0 + 32'(i);
    repeat (2) @(negedge clk);
    chk("rst_we",    {63'd0, ch_we}, 64'd0);
    chk("rst_chd",   {30'd0, ch_d},  64'd0);
    chk("rst_busy",  {63'd0, busy},  64'd0);
    chk("rst_ready", {60'd0, ready}, 64'd0);
    chk("rst_gid",   {62'd0, gid},   64'd0);
    rst_n = 1'b1;

    // MAX_BURST=1: grant and bubble alternate, tags alternate 0,1.
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      valid_b = 4'b0011;
      #1;
      chk($sformatf("mb1_we_c%0d", c), {63'd0, ch_we_b}, {63'd0, bwe[c]});
      if (bwe[c]) chk($sformatf("mb1_chd_c%0d", c), {30'd0, ch_d_b},
                      {30'd0, 2'(btag[c]), 32'hB0 + 32'(btag[c])});
    end
    @(negedge clk);
    valid_b = '0;

    // Single-requester stream, wrap search and no-transfer release.
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      valid = vecs[k].valid;
      stall = vecs[k].stall;
      data  = {4{vecs[k].d}};
      #1;
      chk($sformatf("v%0d_ready", k), {60'd0, ready}, {60'd0, vecs[k].ready});
      chk($sformatf("v%0d_busy", k),  {63'd0, busy},  {63'd0, vecs[k].busy});
      chk($sformatf("v%0d_we", k),    {63'd0, ch_we}, {63'd0, vecs[k].we});
      chk($sformatf("v%0d_chd", k),   {30'd0, ch_d},  {30'd0, vecs[k].chd});
      chk($sformatf("v%0d_gid", k),   {62'd0, gid},   {62'd0, vecs[k].gid});
    end

    // All four continuously valid: bursts of 8 in order 0,1,2,3,0.
    tag_log.delete();
    repeat (41) cycle(4'b1111, 1'b0);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);
    chk("rr_beats", 64'(tag_log.size()), 64'd36);
    for (int k = 0; k < tag_log.size() && k < 36; k++)
      chk($sformatf("rr_tag_%0d", k), 64'(tag_log[k]), 64'((k / 8) % 4));

    // Requester 2 with a 5-cycle stall mid-burst.
    tag_log.delete();
    cyc = 0;
    while (tag_log.size() < 8 && cyc < 40) begin
      cycle(4'b0100, (cyc >= 3 && cyc < 8));
      cyc++;
    end
    chk("stall_cycles", 64'(cyc), 64'd14);
    cycle(4'b0000, 1'b0);
    chk("stall_release_busy", {63'd0, busy}, 64'd0);
    cycle(4'b0000, 1'b0);
    chk("stall_beats", 64'(tag_log.size()), 64'd8);
    for (int k = 0; k < tag_log.size(); k++)
      chk($sformatf("stall_tag_%0d", k), 64'(tag_log[k]), 64'd2);

    // Asynchronous reset mid-burst, then pointer back at 0.
    cycle(4'b1111, 1'b0);
    cycle(4'b1111, 1'b0);
    cycle(4'b1111, 1'b0);
    chk("pre_rst_gid", {62'd0, gid}, 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_we",    {63'd0, ch_we}, 64'd0);
    chk("arst_ready", {60'd0, ready}, 64'd0);
    chk("arst_busy",  {63'd0, busy},  64'd0);
    chk("arst_chd",   {30'd0, ch_d},  64'd0);
    exp_q.delete();
    #2;
    rst_n = 1'b1;
    cycle(4'b1111, 1'b0);
    chk("post_rst_idle", {63'd0, busy}, 64'd0);
    cycle(4'b1111, 1'b0);
    chk("post_rst_busy", {63'd0, busy}, 64'd1);
    chk("post_rst_gid",  {62'd0, gid},  64'd0);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/syrup_outchannel_arbiter.md
Name: syrup_outchannel_arbiter

Overview:
- Round-robin arbiter that shares one SyrupOutChannel write port among NUM_REQ requesters.
- Each requester presents data with a valid/ready handshake.
- The arbiter grants one requester at a time for a burst of up to MAX_BURST beats. It drives the channel's D/WE with the data, prefixed by a requester tag so the far-side SyrupInChannel consumer can demultiplex.
- Sits between user logic and the SyrupOutChannel instance of one DOMAIN/ID.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- TAG_W, 2, tag width; NUM_REQ <= 2**TAG_W required (elaboration error otherwise).
- W_D, 32, payload width per requester.
- MAX_BURST, 8, maximum beats per grant (1..255).

Ports:
- CLK  input  1  clock; all logic on rising edge.
- RST  input  1  reset, asynchronous, active-low (0 = reset).
- REQ_VALID  input  NUM_REQ  per-requester data valid.
- REQ_DATA  input  NUM_REQ*W_D  packed payloads; requester i at [i*W_D +: W_D].
- REQ_READY  output  NUM_REQ  per-requester accept; beat transfers when VALID&READY.
- STALL  input  1  channel almost-full; 1 = accept no new beats.
- CH_D  output  TAG_W+W_D  to SyrupOutChannel D: {tag, payload}.
- CH_WE  output  1  to SyrupOutChannel WE.
- GRANT_ID  output  TAG_W  currently/last granted requester.
- BUSY  output  1  1 while in GRANT state.

Behaviour:
- Reset (RST=0, async):
  - state=IDLE, rr pointer=0, beat count=0.
  - CH_WE=0, CH_D=0, GRANT_ID=0, BUSY=0, REQ_READY=0.
  - Reset mid-burst drops the burst; an in-flight CH_WE is cleared immediately.
- States: IDLE, GRANT.
- IDLE:
  - If any REQ_VALID, select the first asserted index searching upward from the pointer, wrapping mod NUM_REQ.
  - Register it in GRANT_ID, clear count, go to GRANT next cycle.
  - REQ_READY is all-zero in IDLE, giving one bubble cycle per grant.
  - No VALID: stay in IDLE.
- GRANT:
  - REQ_READY[GRANT_ID] = ~STALL (combinational from the registered state and STALL). All other READY bits are 0.
  - On an accepted beat, count increments.
  - Release conditions, either of:
    - REQ_VALID[GRANT_ID]=0 (with or without STALL);
    - an accepted beat that makes count equal MAX_BURST.
  - On release: pointer = (GRANT_ID+1) mod NUM_REQ, state=IDLE.
  - STALL=1 with VALID=1 holds the grant without counting.
- Datapath:
  - Beat accepted in cycle t produces CH_WE=1 and CH_D={GRANT_ID, REQ_DATA slice} in cycle t+1.
  - CH_WE=0 in any cycle following a non-accept; CH_D holds its last value when CH_WE=0.
  - STALL is an almost-full indication: one beat (accepted in the cycle before STALL rose) may still be written after STALL asserts. The channel side must reserve one slot.
- Fairness:
  - The pointer advances only on release, so every continuously-valid requester is granted within NUM_REQ grants.
  - Worst-case wait is (NUM_REQ-1)*(MAX_BURST+1) cycles plus stall time.
- Edge cases:
  - Pointer wraps NUM_REQ-1 → 0.
  - VALID deasserting in the same cycle READY would be high: no transfer, release.
  - MAX_BURST=1: alternate grant/bubble.
  - Tag bits above the NUM_REQ range are never emitted.

Test Plan:
- Reset then REQ_VALID=4'b0001, data 0x10,0x11,0x12 then VALID low → CH_WE pulses 3 cycles with CH_D={2'd0,0x10..0x12}, starting 2 cycles after VALID rises; BUSY falls after VALID drop.
- All four VALID continuously, MAX_BURST=8 → grants in order 0,1,2,3,0; exactly 8 beats each; one idle CH_WE cycle between bursts; tags match GRANT_ID.
- Requester 2 streaming, STALL=1 for 5 cycles mid-burst → READY[2]=0 during STALL, at most one CH_WE after STALL rises, no beats lost or duplicated, count resumes to 8 total.
- Pointer at 3 with only REQ_VALID[1]=1 → wrap search grants 1; next arbitration starts from 2.
- RST driven low asynchronously mid-burst (between clock edges) → CH_WE, REQ_READY, BUSY go 0 immediately; after release state IDLE, pointer 0, requester 0 wins if all VALID.
- MAX_BURST=1, requesters 0 and 1 valid → CH_WE pattern 1,0,1,0 with tags alternating 0,1.
